mem_port_arbiter: RTL and testbench

- Shares the single RAM port between the datapath's instruction-fetch and data-access requests.
- Grants one request at a time, latches its address and store data, and drives the RAM strobes until the RAM signals ready.
- Returns a registered one-cycle hit and load data to the requester.
- Data has priority, with a starvation guard for fetch and a watchdog timeout that raises an error.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data has priority; a starvation guard forces fetch and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err,
  output logic        ram_REN,
  output logic        ram_WEN,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready
);

  // The wait counter only has to reach TIMEOUT-1; the abort fires on the next miss.
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [StvW-1:0] StvLimit = StvW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIacc, StDacc, StResp} state_e;

  state_e          state_q;
  logic [TmoW-1:0] tmo_q;
  logic [StvW-1:0] starve_q;
  logic            data_req;
  logic            data_win;

  assign data_req = dREN | dWEN;
  assign data_win = data_req && ((starve_q < StvLimit) || !iREN);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      starve_q  <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      err       <= 1'b0;
      ram_REN   <= 1'b0;
      ram_WEN   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      iload     <= '0;
      dload     <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (data_win) begin
            state_q   <= StDacc;
            ram_WEN   <= dWEN;
            ram_REN   <= ~dWEN;
            ram_addr  <= daddr;
            ram_store <= dstore;
            tmo_q     <= '0;
            starve_q  <= iREN ? starve_q + 1'b1 : '0;
          end else if (iREN) begin
            state_q  <= StIacc;
            ram_REN  <= 1'b1;
            ram_WEN  <= 1'b0;
            ram_addr <= iaddr;
            tmo_q    <= '0;
            starve_q <= '0;
          end
        end
        StIacc, StDacc: begin
          if (ram_ready) begin
            state_q <= StResp;
            ram_REN <= 1'b0;
            ram_WEN <= 1'b0;
            if (state_q == StIacc) begin
              ihit  <= 1'b1;
              iload <= ram_load;
            end else begin
              dhit <= 1'b1;
              // ram_REN doubles as the latched op: high only for a data read here.
              if (ram_REN) dload <= ram_load;
            end
          end else if (tmo_q == TmoLast) begin
            state_q <= StIdle;
            ram_REN <= 1'b0;
            ram_WEN <= 1'b0;
            err     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a schedule-based access model predicts every output
// each cycle, and directed scenarios pin the model with literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 5;
  localparam int unsigned SL = 4;
  localparam int KInstr = 0;
  localparam int KRead  = 1;
  localparam int KWrite = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        err;
  logic        ram_REN;
  logic        ram_WEN;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;

  mem_port_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .ihit      (ihit),
    .dhit      (dhit),
    .iload     (iload),
    .dload     (dload),
    .err       (err),
    .ram_REN   (ram_REN),
    .ram_WEN   (ram_WEN),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_ready (ram_ready)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: an access is a grant followed by a known schedule. With latency L (the ACC cycle
  // in which ram_ready rises), RESP is cycle L+1 after the grant and IDLE is cycle L+2; if L
  // exceeds the timeout, cycle TO+1 is IDLE with err.
  bit          m_busy   = 0;
  int          m_t      = 0;
  int          m_lat    = 0;
  int          m_kind   = 0;
  int          m_starve = 0;
  logic        exp_ren   = 0, exp_wen = 0, exp_ihit = 0, exp_dhit = 0, exp_err = 0;
  logic [31:0] exp_addr  = 0, exp_store = 0, exp_iload = 0, exp_dload = 0;
  int          grant_log[$];

  int          force_lat     = 0;
  bit          force_load_en = 0;
  logic [31:0] force_load    = 0;

  function automatic int pick_lat();
    int r;
    if (force_lat != 0) return force_lat;
    r = int'($urandom_range(0, 9));
    if (r == 0) return int'(TO) + 3;
    if (r == 1) return int'(TO);
    return int'($urandom_range(1, 4));
  endfunction

  task automatic advance();
    exp_ihit = 0;
    exp_dhit = 0;
    exp_err  = 0;
    if (!nRST) begin
      m_busy = 0; m_starve = 0;
      exp_ren = 0; exp_wen = 0;
      exp_addr = 0; exp_store = 0; exp_iload = 0; exp_dload = 0;
    end else if (!m_busy) begin
      if ((dREN || dWEN) && (m_starve < int'(SL) || !iREN)) begin
        m_kind    = dWEN ? KWrite : KRead;
        exp_addr  = daddr;
        exp_store = dstore;
        m_starve  = iREN ? m_starve + 1 : 0;
        m_busy    = 1;
      end else if (iREN) begin
        m_kind   = KInstr;
        exp_addr = iaddr;
        m_starve = 0;
        m_busy   = 1;
      end
      if (m_busy) begin
        m_t   = 1;
        m_lat = pick_lat();
        exp_ren = (m_kind != KWrite);
        exp_wen = (m_kind == KWrite);
        grant_log.push_back(m_kind);
      end
    end else begin
      m_t++;
      if (m_lat <= int'(TO) && m_t == m_lat + 1) begin
        exp_ren = 0; exp_wen = 0;
        if (m_kind == KInstr) begin
          exp_ihit = 1; exp_iload = ram_load;
        end else begin
          exp_dhit = 1;
          if (m_kind == KRead) exp_dload = ram_load;
        end
      end else if (m_lat <= int'(TO) && m_t == m_lat + 2) begin
        m_busy = 0;
      end else if (m_lat > int'(TO) && m_t == int'(TO) + 1) begin
        m_busy = 0; exp_err = 1; exp_ren = 0; exp_wen = 0;
      end
    end
  endtask

  // Called at a negedge with requests already driven: plays the RAM, updates the model.
  task automatic step();
    int lim;
    bit acc;
    lim = (m_lat > int'(TO)) ? int'(TO) : m_lat;
    acc = m_busy && (m_t <= lim);
    ram_load  = force_load_en ? force_load : $urandom;
    ram_ready = acc ? (m_t == m_lat) : 1'($urandom_range(0, 1));
    advance();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    iREN = 0; dREN = 0; dWEN = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  always @(posedge CLK) begin
    #1;
    check("ram_REN", 32'(ram_REN), 32'(exp_ren));
    check("ram_WEN", 32'(ram_WEN), 32'(exp_wen));
    check("ram_addr", ram_addr, exp_addr);
    check("ram_store", ram_store, exp_store);
    check("ihit", 32'(ihit), 32'(exp_ihit));
    check("dhit", 32'(dhit), 32'(exp_dhit));
    check("err", 32'(err), 32'(exp_err));
    check("iload", iload, exp_iload);
    check("dload", dload, exp_dload);
    check("strobe_excl", 32'(ram_REN & ram_WEN), 32'd0);
    check("pulse_excl", 32'(32'(ihit) + 32'(dhit) + 32'(err) > 1), 32'd0);
  end

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_load = 0; ram_ready = 0;
    @(negedge CLK);
    step();
    step();
    nRST = 1;
    check("rst_ren", 32'(ram_REN), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_iload", iload, 32'd0);

    // Single fetch with an immediately ready RAM.
    iREN = 1; iaddr = 32'h0000_0040;
    force_lat = 1; force_load_en = 1; force_load = 32'h2008_0001;
    step();
    iREN = 0;
    check("t1_ren", 32'(ram_REN), 32'd1);
    check("t1_addr", ram_addr, 32'h40);
    step();
    check("t1_ihit", 32'(ihit), 32'd1);
    check("t1_ren_drop", 32'(ram_REN), 32'd0);
    check("t1_iload", iload, 32'h2008_0001);
    step();
    check("t1_ihit_pulse", 32'(ihit), 32'd0);

    // Data beats fetch; fetch follows once the data access completes.
    iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h100;
    force_lat = 3; force_load = 32'h1234_5678;
    step();
    dREN = 0;
    check("t2_daddr", ram_addr, 32'h100);
    step(); step(); step();
    check("t2_dhit", 32'(dhit), 32'd1);
    check("t2_no_ihit", 32'(ihit), 32'd0);
    check("t2_dload", dload, 32'h1234_5678);
    step();
    step();
    iREN = 0;
    check("t2_iaddr", ram_addr, 32'h80);
    check("t2_iren", 32'(ram_REN), 32'd1);
    step(); step(); step();
    check("t2_ihit", 32'(ihit), 32'd1);
    step();

    // Write wins over read when both are requested.
    dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; force_lat = 2;
    step();
    dWEN = 0; dREN = 0;
    check("t3_wen", 32'(ram_WEN), 32'd1);
    check("t3_ren", 32'(ram_REN), 32'd0);
    check("t3_store", ram_store, 32'hDEAD_BEEF);
    step(); step();
    check("t3_dhit", 32'(dhit), 32'd1);
    check("t3_dload_kept", dload, 32'h1234_5678);
    idle(2);

    // Starvation guard with both requests held and single-cycle RAM.
    grant_log.delete();
    iREN = 1; dREN = 1; iaddr = 32'h300; daddr = 32'h400; force_lat = 1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i + 1 == 4)  check("t4_data_addr", ram_addr, 32'h400);
      if (i + 1 == 13) check("t4_fetch_addr", ram_addr, 32'h300);
    end
    check("t4_grants", 32'(grant_log.size()), 32'd6);
    if (grant_log.size() == 6) begin
      check("t4_g3", 32'(grant_log[3]), 32'(KRead));
      check("t4_g4", 32'(grant_log[4]), 32'(KInstr));
      check("t4_g5", 32'(grant_log[5]), 32'(KRead));
    end
    idle(2);

    // Watchdog abort, then a fresh request is accepted.
    dREN = 1; daddr = 32'h500; force_lat = 99;
    step();
    dREN = 0;
    for (int i = 0; i < int'(TO) - 1; i++) step();
    check("t5_still_waiting", 32'(ram_REN), 32'd1);
    step();
    check("t5_ren_drop", 32'(ram_REN), 32'd0);
    check("t5_err", 32'(err), 32'd1);
    check("t5_no_dhit", 32'(dhit), 32'd0);
    iREN = 1; iaddr = 32'h600; force_lat = 1;
    step();
    iREN = 0;
    check("t5_err_pulse", 32'(err), 32'd0);
    check("t5_new_addr", ram_addr, 32'h600);
    step();
    check("t5_ihit", 32'(ihit), 32'd1);
    idle(2);

    // Reset during a data wait cycle.
    dREN = 1; daddr = 32'h700; force_lat = 99;
    step();
    dREN = 0;
    step();
    nRST = 0;
    step();
    nRST = 1;
    check("t6_ren", 32'(ram_REN), 32'd0);
    check("t6_addr", ram_addr, 32'd0);
    check("t6_dload", dload, 32'd0);
    idle(6);
    check("t6_no_dhit", 32'(dhit), 32'd0);

    // Randomized traffic, including occasional resets.
    force_lat = 0; force_load_en = 0;
    for (int i = 0; i < 3000; i++) begin
      nRST   = ($urandom_range(0, 249) != 0);
      iREN   = 1'($urandom_range(0, 1));
      dREN   = ($urandom_range(0, 2) == 0);
      dWEN   = ($urandom_range(0, 3) == 0);
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      step();
    end
    nRST = 1;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
